pool_window_gen: RTL
====================

POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 Parameter DWIDTH, default 8: pixel width in bits.
REQ-002 Parameter IMG_W, default 28: pixels per image row, legal range 3..256.
REQ-003 Parameter IMG_H, default 28: rows per frame, legal range 3..256.
REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_pixel, input, DWIDTH: raster-order pixel from the BRAM reader.
REQ-007 Port in_valid, input, 1: in_pixel is valid.
REQ-008 Port in_ready, output, 1: block accepts in_pixel this cycle.
REQ-009 Port win, output, 9*DWIDTH: packed 3x3 window feeding the averaging pooling kernel.
REQ-010 Port win_valid, output, 1: win holds a valid window.
REQ-011 Port win_ready, input, 1: downstream consumes win this cycle.
REQ-012 Port frame_done, output, 1: one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-013 Pixel accept SHALL occur on cycles where in_valid and in_ready are both 1; no other cycle changes counters, line buffers or the window.
REQ-014 in_ready SHALL equal (not win_valid) or win_ready; it is combinational, with no added bubble.
REQ-015 Column counter col (0..IMG_W-1) SHALL increment on accept, wrap to 0 after IMG_W-1, and on wrap increment row (0..IMG_H-1).
REQ-016 row SHALL wrap to 0 after IMG_H-1 together with col, starting the next frame with no idle cycle.
REQ-017 Two line buffers, each of IMG_W entries, SHALL hold rows r-1 and r-2; on accept, the entry at col shifts from buffer 1 to buffer 2, and in_pixel is written to buffer 1.
REQ-018 The 3x3 window register SHALL shift left one column on accept, loading {buf2[col], buf1[col], in_pixel} as the new right column.
REQ-019 A window SHALL be produced for an accept at (row,col) with row>=2 and col>=2, with stride 1 and no padding: (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-020 Packing SHALL be win[(i*3+j)*DWIDTH +: DWIDTH] = pixel(row-2+i, col-2+j), for i,j in 0..2; i=0 is the top (oldest) row and j=0 the leftmost column.
REQ-021 win_valid SHALL rise the cycle after a producing accept, i.e. 1-cycle latency.
REQ-022 win SHALL be stable while win_valid=1 and win_ready=0.
REQ-023 win_valid SHALL clear after a cycle with win_ready=1 unless a new producing accept occurs in that same cycle, in which case it stays 1 with the new window (full throughput, 1 window/cycle).
REQ-024 Windows straddling a row boundary (col<2) SHALL never assert win_valid, even though the window register holds mixed-row data.
REQ-025 frame_done SHALL pulse for exactly one cycle, coincident with the cycle after accepting (IMG_H-1, IMG_W-1).
REQ-026 Line buffer contents SHALL carry across frames; they are not cleared at frame wrap, because row<2 gating masks stale data.

Reset
REQ-027 While rst_n=0, regardless of clk: col=0, row=0, win_valid=0, frame_done=0, win=0.
REQ-028 Line buffers SHALL NOT require reset.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame and any pending window; the first accept after release is pixel (0,0).
REQ-030 in_ready SHALL read 1 during reset, since it follows win_valid=0, but no accept occurs until rst_n=1.

Structure
REQ-031 DWIDTH, the window size constant 3, and the window-index macro (i*3+j) SHALL live in the shared pooling package, also used by the pooling kernels.
REQ-032 One sub-module, pool_line_buffer (IMG_W x DWIDTH, single read/write at col, inferable as distributed RAM or BRAM), SHALL be instantiated twice.
REQ-033 Counters SHALL be sized $clog2(IMG_W) and $clog2(IMG_H) bits.

Verification
REQ-034 Test 1: IMG_W=IMG_H=4, pixels 0x00..0x0F, continuous valid, win_ready=1 -> 4 windows. First window: win[7:0]=0x00, win[71:64]=0x0A, centre win[39:32]=0x05. Last window: win[7:0]=0x05, win[71:64]=0x0F. frame_done pulses once.
REQ-035 Test 2: Same stream with win_ready held 0 after the first window -> in_ready=0, win constant at the first window; releasing win_ready resumes with no window lost or duplicated.
REQ-036 Test 3: Random in_valid gaps (50%) with random win_ready -> window sequence identical to Test 1, scoreboarded against a reference model.
REQ-037 Test 4: Two back-to-back frames (second frame = pixels 0x10..0x1F) -> 8 windows total; first window of frame 2 has win[7:0]=0x10, win[71:64]=0x1A; no window at frame boundary.
REQ-038 Test 5: rst_n pulsed low after pixel 0x07, then a full frame -> win_valid=0 immediately on reset; the following frame yields exactly 4 correct windows.
REQ-039 Test 6: IMG_W=5, IMG_H=3, pixels 0..14 -> exactly 3 windows with win[71:64]=0x0C, 0x0D, 0x0E; none at col 0 or col 1.

Source files
------------

// File: rtl/pool_window_gen_pkg.sv
// Shared pooling constants: default pixel width, window size and window tap indexing.
// Imported by the window generator and by the pooling kernels that consume its output.
package pool_window_gen_pkg;

  localparam int POOL_DWIDTH = 8;
  localparam int POOL_K      = 3;
  localparam int POOL_TAPS   = POOL_K * POOL_K;

  // Tap (i, j) of the packed window: i = row (0 = oldest), j = column (0 = leftmost).
  function automatic int win_idx(input int i, input int j);
    return i * POOL_K + j;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One image row of pixels, a single address used for both read and write.
// The read is asynchronous so the old entry can be forwarded while it is overwritten.
module pool_line_buffer #(
  parameter int DEPTH  = 28,
  parameter int DWIDTH = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DWIDTH-1:0] i_wdata,
  output logic [DWIDTH-1:0] o_rdata
);

  logic [DWIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/pool_window_gen.sv
// Raster-order pixel stream to 3x3 sliding window generator (stride 1, no padding).
// Two line buffers hold rows r-1 and r-2; windows are emitted only once row and col are both >= 2.
module pool_window_gen
  import pool_window_gen_pkg::*;
#(
  parameter int DWIDTH = POOL_DWIDTH,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DWIDTH-1:0]           in_pixel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [POOL_TAPS*DWIDTH-1:0] win,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic                        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_win_valid;
  logic              r_frame_done;
  logic [DWIDTH-1:0] r_win [POOL_K][POOL_K];

  logic              w_accept;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_produce;
  logic [DWIDTH-1:0] w_buf1_rd;
  logic [DWIDTH-1:0] w_buf2_rd;

  assign in_ready   = ~r_win_valid | win_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  // Row-straddling windows (col < 2) and the first two rows hold stale data and are masked here.
  assign w_produce  = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));

  pool_line_buffer #(.DEPTH(IMG_W), .DWIDTH(DWIDTH), .AW(CW)) u_buf1 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (in_pixel),
    .o_rdata (w_buf1_rd)
  );

  pool_line_buffer #(.DEPTH(IMG_W), .DWIDTH(DWIDTH), .AW(CW)) u_buf2 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (w_buf1_rd),
    .o_rdata (w_buf2_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '{default: '{default: '0}};
    end else if (w_accept) begin
      for (int i = 0; i < POOL_K; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_buf2_rd;
      r_win[1][2] <= w_buf1_rd;
      r_win[2][2] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_produce)      r_win_valid <= 1'b1;
      else if (win_ready) r_win_valid <= 1'b0;
      r_frame_done <= w_accept & w_col_last & w_row_last;
    end
  end

  for (genvar gi = 0; gi < POOL_K; gi++) begin : g_row
    for (genvar gj = 0; gj < POOL_K; gj++) begin : g_col
      assign win[win_idx(gi, gj)*DWIDTH +: DWIDTH] = r_win[gi][gj];
    end
  end

  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule
